// File: rtl/taken_pred_pkg.sv
// Shared types and helpers for the taken/not-taken predictor table.
// Defining TAKEN_PRED_BYPASS_EN changes the table's read path.
package taken_pred_pkg;

    // Widest counter sat_step can handle; CNT_W must not exceed this.
    localparam int MAX_CNT_W = 16;
    localparam int SAT_W     = MAX_CNT_W + 1;

    typedef enum logic {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } tp_state_e;

    // Weakly not-taken: the value just below the taken threshold.
    function automatic int unsigned init_val(input int unsigned cnt_w);
        return (1 << (cnt_w - 1)) - 1;
    endfunction

    // One-bit extension keeps the increment from wrapping before the clamp.
    function automatic logic [MAX_CNT_W-1:0] sat_step(input logic [MAX_CNT_W-1:0] cnt,
                                                      input logic                 taken,
                                                      input int unsigned          cnt_w);
        logic [SAT_W-1:0] ext;
        logic [SAT_W-1:0] top;
        logic [SAT_W-1:0] nxt;
        ext = {1'b0, cnt};
        top = SAT_W'((1 << cnt_w) - 1);
        if (taken) begin
            nxt = ext + SAT_W'(1);
            if (nxt > top) nxt = top;
        end else if (ext == '0) begin
            nxt = '0;
        end else begin
            nxt = ext - SAT_W'(1);
        end
        return nxt[MAX_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/taken_pred_sweep.sv
// Initialisation sweep controller: walks a write pointer over the table after
// reset or a clear request and reports busy until the last entry is written.
module taken_pred_sweep
    import taken_pred_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_req_i,
    output logic             busy_o,
    output logic [IDX_W-1:0] wr_idx_o
);

    tp_state_e        state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SWEEP;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            SWEEP: begin
                if (clr_req_i) begin
                    ptr_d = '0;
                end else if (ptr_q == IDX_W'(DEPTH - 1)) begin
                    state_d = RUN;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + IDX_W'(1);
                end
            end
            RUN: begin
                if (clr_req_i) begin
                    state_d = SWEEP;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = SWEEP;
                ptr_d   = '0;
            end
        endcase
    end

    assign busy_o   = (state_q == SWEEP);
    assign wr_idx_o = ptr_q;

endmodule

// File: rtl/taken_pred_table.sv
// Table of DEPTH saturating CNT_W-bit taken counters with a 1-cycle lookup.
// Optional macro TAKEN_PRED_BYPASS_EN forwards a same-cycle update to the lookup.
module taken_pred_table
    import taken_pred_pkg::*;
#(
    parameter int          CNT_W    = 2,
    parameter int          DEPTH    = 64,
    parameter int          IDX_W    = $clog2(DEPTH),
    parameter int unsigned INIT_VAL = init_val(CNT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pred_valid_i,
    input  logic [IDX_W-1:0] pred_idx_i,
    output logic             resp_valid_o,
    output logic             resp_taken_o,
    output logic             resp_strong_o,
    input  logic             upd_valid_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i,
    input  logic             clr_req_i,
    output logic             busy_o
);

    logic [CNT_W-1:0] mem [DEPTH];

    logic             busy;
    logic [IDX_W-1:0] sweep_idx;
    logic             upd_fire;
    logic [CNT_W-1:0] upd_cur;
    logic [CNT_W-1:0] upd_next;
    logic [CNT_W-1:0] rd_val;
    logic             resp_valid_q;
    logic             resp_taken_q, resp_taken_d;
    logic             resp_strong_q, resp_strong_d;

    taken_pred_sweep #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_sweep (
        .clk       (clk),
        .rst       (rst),
        .clr_req_i (clr_req_i),
        .busy_o    (busy),
        .wr_idx_o  (sweep_idx)
    );

    // A clear in the same cycle wins over an update, so the update is dropped.
    assign upd_fire = upd_valid_i && !clr_req_i && !busy;

    always_comb begin
        upd_cur  = mem[upd_idx_i];
        upd_next = CNT_W'(sat_step(MAX_CNT_W'(upd_cur), upd_taken_i, CNT_W));
        rd_val   = mem[pred_idx_i];
`ifdef TAKEN_PRED_BYPASS_EN
        if (upd_fire && (upd_idx_i == pred_idx_i)) begin
            rd_val = upd_next;
        end
`endif
        resp_taken_d  = !busy && rd_val[CNT_W-1];
        resp_strong_d = !busy && ((rd_val == '0) || (rd_val == '1));
    end

    // Storage has no reset so it can map onto RAM; the sweep initialises it.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[sweep_idx] <= CNT_W'(INIT_VAL);
        end else if (upd_fire) begin
            mem[upd_idx_i] <= upd_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid_q  <= 1'b0;
            resp_taken_q  <= 1'b0;
            resp_strong_q <= 1'b0;
        end else begin
            resp_valid_q  <= pred_valid_i;
            resp_taken_q  <= resp_taken_d;
            resp_strong_q <= resp_strong_d;
        end
    end

    assign resp_valid_o  = resp_valid_q;
    assign resp_taken_o  = resp_taken_q;
    assign resp_strong_o = resp_strong_q;
    assign busy_o        = busy;

endmodule

// File: tb/tb_taken_pred_table.sv
// Self-checking bench for taken_pred_table against a table-of-integers model.
// Build with TAKEN_PRED_BYPASS_EN defined to check the bypass read path.
module tb_taken_pred_table;

    localparam int CNT_W = 2;
    localparam int DEPTH = 64;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int MAXV  = (1 << CNT_W) - 1;
    localparam int HALF  = 1 << (CNT_W - 1);
    localparam int INITV = HALF - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             pred_valid_i = 1'b0;
    logic [IDX_W-1:0] pred_idx_i = '0;
    logic             resp_valid_o;
    logic             resp_taken_o;
    logic             resp_strong_o;
    logic             upd_valid_i = 1'b0;
    logic [IDX_W-1:0] upd_idx_i = '0;
    logic             upd_taken_i = 1'b0;
    logic             clr_req_i = 1'b0;
    logic             busy_o;

    int checks = 0;
    int errors = 0;

    int model [DEPTH];
    int sweepLeft = DEPTH;

    taken_pred_table #(
        .CNT_W (CNT_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pred_valid_i  (pred_valid_i),
        .pred_idx_i    (pred_idx_i),
        .resp_valid_o  (resp_valid_o),
        .resp_taken_o  (resp_taken_o),
        .resp_strong_o (resp_strong_o),
        .upd_valid_i   (upd_valid_i),
        .upd_idx_i     (upd_idx_i),
        .upd_taken_i   (upd_taken_i),
        .clr_req_i     (clr_req_i),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic int satNext(input int v, input bit taken);
        if (taken) return (v + 1 > MAXV) ? MAXV : v + 1;
        return (v == 0) ? 0 : v - 1;
    endfunction

    // One clock of stimulus; the model advances at the edge and outputs are
    // checked 1 time unit later.
    task automatic applyStimulus(input bit pv, input int pidx, input bit uv,
                                 input int uidx, input bit ut, input bit clr);
        int val;
        bit expT;
        bit expS;
        pred_valid_i = pv;
        pred_idx_i   = IDX_W'(pidx);
        upd_valid_i  = uv;
        upd_idx_i    = IDX_W'(uidx);
        upd_taken_i  = ut;
        clr_req_i    = clr;
        @(posedge clk);
        expT = 1'b0;
        expS = 1'b0;
        if (sweepLeft == 0) begin
            val = model[pidx];
`ifdef TAKEN_PRED_BYPASS_EN
            if (uv && !clr && uidx == pidx) val = satNext(val, ut);
`endif
            expT = (val >= HALF);
            expS = (val == 0) || (val == MAXV);
        end
        if (clr) begin
            sweepLeft = DEPTH;
        end else if (sweepLeft > 0) begin
            sweepLeft--;
            if (sweepLeft == 0) begin
                for (int i = 0; i < DEPTH; i++) model[i] = INITV;
            end
        end else if (uv) begin
            model[uidx] = satNext(model[uidx], ut);
        end
        #1;
        checkOutput("resp_valid", resp_valid_o, pv);
        if (pv) begin
            checkOutput("resp_taken", resp_taken_o, expT);
            checkOutput("resp_strong", resp_strong_o, expS);
        end
        checkOutput("busy", busy_o, (sweepLeft > 0));
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic checkResetState();
        checkOutput("rst_resp_valid", resp_valid_o, 0);
        checkOutput("rst_resp_taken", resp_taken_o, 0);
        checkOutput("rst_resp_strong", resp_strong_o, 0);
        checkOutput("rst_busy", busy_o, 1);
    endtask

    task automatic doReset();
        rst = 1'b1;
        pred_valid_i = 1'b0;
        upd_valid_i  = 1'b0;
        clr_req_i    = 1'b0;
        sweepLeft    = DEPTH;
        #2;
        checkResetState();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int busyCount;

    initial begin
        $display("[TB] starting, CNT_W=%0d DEPTH=%0d", CNT_W, DEPTH);
        #1;
        doReset();

        // Sweep after reset: lookups answered with zeros, busy for DEPTH cycles.
        busyCount = 0;
        for (int c = 0; c < DEPTH + 4; c++) begin
            applyStimulus($urandom_range(0, 1), $urandom_range(0, DEPTH - 1),
                          $urandom_range(0, 1), $urandom_range(0, DEPTH - 1), $urandom_range(0, 1), 1'b0);
            if (busy_o) busyCount++;
        end
        checkOutput("sweep_len", busyCount, DEPTH - 1);

        // Every entry reads the initial value.
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, i, 1'b0, 0, 1'b0, 1'b0);

        // Saturation at both ends on idx 7.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 7, 1'b1, 7, 1'b1, 1'b0);
        applyStimulus(1'b1, 7, 1'b0, 0, 1'b0, 1'b0);
        checkOutput("sat_hi_taken", resp_taken_o, 1);
        checkOutput("sat_hi_strong", resp_strong_o, 1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 7, 1'b1, 7, 1'b0, 1'b0);
        applyStimulus(1'b1, 7, 1'b0, 0, 1'b0, 1'b0);
        checkOutput("sat_lo_taken", resp_taken_o, 0);
        checkOutput("sat_lo_strong", resp_strong_o, 1);

        // Same-cycle lookup and update on idx 3 holding the initial value.
        applyStimulus(1'b1, 3, 1'b1, 3, 1'b1, 1'b0);
`ifdef TAKEN_PRED_BYPASS_EN
        checkOutput("bypass_taken", resp_taken_o, 1);
`else
        checkOutput("nobypass_taken", resp_taken_o, 0);
`endif

        // Clear mid-run after training idx 0; an update during busy is dropped.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0, 1'b1, 0, 1'b1, 1'b0);
        applyStimulus(1'b1, 0, 1'b1, 0, 1'b1, 1'b1);
        busyCount = 0;
        for (int c = 0; c < DEPTH; c++) begin
            if (busy_o) busyCount++;
            applyStimulus(1'b0, 0, (c == 20), 0, 1'b1, 1'b0);
        end
        checkOutput("clr_busy_len", busyCount, DEPTH);
        applyStimulus(1'b1, 0, 1'b0, 0, 1'b0, 1'b0);
        checkOutput("clr_idx0_taken", resp_taken_o, 0);
        checkOutput("clr_idx0_strong", resp_strong_o, 0);

        // Reset pulsed mid-sweep at pointer 30 clears the outputs at once.
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        for (int c = 0; c < 30; c++) applyStimulus(1'b1, c, 1'b0, 0, 1'b0, 1'b0);
        checkOutput("pre_rst_valid", resp_valid_o, 1);
        #2;
        rst = 1'b1;
        #1;
        checkResetState();
        @(posedge clk);
        #1;
        rst = 1'b0;
        sweepLeft = DEPTH;
        busyCount = 0;
        for (int c = 0; c < DEPTH + 2; c++) begin
            if (busy_o) busyCount++;
            applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
        end
        checkOutput("rst_sweep_len", busyCount, DEPTH);

        // Random traffic, biased to a few indices to force collisions.
        for (int c = 0; c < 3000; c++) begin
            int pidx;
            int uidx;
            pidx = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH - 1);
            uidx = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH - 1);
            if ($urandom_range(0, 3) == 0) uidx = pidx;
            applyStimulus($urandom_range(0, 3) != 0, pidx, $urandom_range(0, 2) != 0, uidx,
                          $urandom_range(0, 1), $urandom_range(0, 499) == 0);
        end

        idleCycles(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
